// File: rtl/gate_output_monitor.sv
// gate_output_monitor: captures {t,n,r,k,m} on each sampled change as a {vec, ts} record
// into a small FIFO drained over valid/ready. Define GATE_MON_PARITY_EN to add out_parity.
module gate_output_monitor #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic                     t,
  input  logic                     n,
  input  logic                     r,
  input  logic                     k,
  input  logic                     m,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5+TS_W-1:0]        out_data,
  output logic [CNT_W-1:0]         change_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef GATE_MON_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int REC_W = 5 + TS_W;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic rec_parity(input logic [REC_W-1:0] rec);
    return ^rec;
  endfunction

  logic [TS_W-1:0]  ts_p1;
  logic [4:0]       prev_p1;
  logic [AW-1:0]    head_p1;
  logic [AW-1:0]    tail_p1;
  logic [LW-1:0]    level_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             ovf_p1;
  logic [REC_W-1:0] mem_p1 [DEPTH];
`ifdef GATE_MON_PARITY_EN
  logic             par_mem_p1 [DEPTH];
`endif

  logic [4:0]       vec_p0;
  logic [REC_W-1:0] rec_p0;
  logic             change_p0;
  logic             full_p0;
  logic             pop_p0;
  logic             push_p0;
  logic             drop_p0;

  // Stage p0: detect change against the last sampled vector and arbitrate push/pop
  always_comb begin
    vec_p0    = {t, n, r, k, m};
    rec_p0    = {vec_p0, ts_p1};
    change_p0 = sample_en && (vec_p0 != prev_p1);
    full_p0   = (level_p1 == FULL_LVL);
    pop_p0    = out_valid && out_ready;
    // A pop in the same cycle frees the slot the push needs when full.
    push_p0   = change_p0 && (!full_p0 || pop_p0);
    drop_p0   = change_p0 && full_p0 && !pop_p0;
  end

  // Stage p1: control state (reset applies here only)
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_p1    <= '0;
      prev_p1  <= '0;
      head_p1  <= '0;
      tail_p1  <= '0;
      level_p1 <= '0;
      cnt_p1   <= '0;
      ovf_p1   <= 1'b0;
    end else begin
      ts_p1 <= ts_p1 + 1'b1;
      if (sample_en) prev_p1 <= vec_p0;
      if (change_p0) cnt_p1 <= sat_inc(cnt_p1);
      if (drop_p0) ovf_p1 <= 1'b1;
      if (push_p0) tail_p1 <= tail_p1 + 1'b1;
      if (pop_p0) head_p1 <= head_p1 + 1'b1;
      unique case ({push_p0, pop_p0})
        2'b10:   level_p1 <= level_p1 + 1'b1;
        2'b01:   level_p1 <= level_p1 - 1'b1;
        default: level_p1 <= level_p1;
      endcase
    end
  end

  // Stage p1: record storage, written only on push so it needs no reset
  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_p1[tail_p1] <= rec_p0;
`ifdef GATE_MON_PARITY_EN
      par_mem_p1[tail_p1] <= rec_parity(rec_p0);
`endif
    end
  end

  // Output: head record, forced to zero when empty so reset leaves out_data at 0
  always_comb begin
    out_valid  = (level_p1 != '0);
    out_data   = out_valid ? mem_p1[head_p1] : '0;
    change_cnt = cnt_p1;
    overflow   = ovf_p1;
    fifo_level = level_p1;
`ifdef GATE_MON_PARITY_EN
    out_parity = out_valid ? par_mem_p1[head_p1] : 1'b0;
`endif
  end

`ifndef GATE_MON_PARITY_EN
  logic unused_p0;
  assign unused_p0 = rec_parity(rec_p0);
`endif

endmodule

// File: tb/tb_gate_output_monitor.sv
// Testbench for gate_output_monitor: queue-based reference model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_gate_output_monitor;

  localparam int DEPTH = 4;
  localparam int TS_W  = 8;
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        t, n, r, k, m;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic [7:0]  change_cnt;
  logic        overflow;
  logic [2:0]  fifo_level;
`ifdef GATE_MON_PARITY_EN
  logic        out_parity;
`endif

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 1'b0;

  gate_output_monitor #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .t(t), .n(n), .r(r), .k(k), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .change_cnt(change_cnt), .overflow(overflow), .fifo_level(fifo_level)
`ifdef GATE_MON_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of records, a wrapping timestamp, a saturating count.
  logic [12:0] q[$];
  logic [7:0]  m_ts;
  logic [4:0]  m_prev;
  logic [7:0]  m_cnt;
  logic        m_ovf;
  logic [4:0]  m_vec;
  bit          m_pop;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ts = 8'd0; m_prev = 5'd0; m_cnt = 8'd0; m_ovf = 1'b0;
    end else begin
      m_vec = {t, n, r, k, m};
      m_pop = (q.size() != 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (sample_en && (m_vec != m_prev)) begin
        if (q.size() < DEPTH) q.push_back({m_vec, m_ts});
        else m_ovf = 1'b1;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
      if (sample_en) m_prev = m_vec;
      m_ts = m_ts + 8'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("model_level", 32'(fifo_level), 32'(q.size()));
      chk("model_cnt", 32'(change_cnt), 32'(m_cnt));
      chk("model_ovf", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) begin
        chk("model_data", 32'(out_data), 32'(q[0]));
`ifdef GATE_MON_PARITY_EN
        chk("model_parity", 32'(out_parity), 32'(^q[0]));
`endif
      end
    end
  end

  task automatic step(input logic en, input logic [4:0] v, input logic rdy);
    sample_en = en;
    {t, n, r, k, m} = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step(1'b0, 5'd0, 1'b0);
    rst = 1'b0;
  endtask

  logic [4:0] ov_v [6];

  initial begin
    ov_v = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    rst = 1'b1; sample_en = 1'b0; {t, n, r, k, m} = 5'd0; out_ready = 1'b0;
    do_reset(2);
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_cnt", 32'(change_cnt), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Basic capture: change at cycle 5 carries ts=5
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'b10110, 1'b1);
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_data", 32'(out_data), 32'({5'b10110, 8'd5}));
    chk("cap_cnt", 32'(change_cnt), 32'd1);

    // Repeated identical samples produce nothing
    for (int i = 0; i < 10; i++) step(1'b1, 5'b10110, 1'b1);
    chk("nochg_cnt", 32'(change_cnt), 32'd1);
    chk("nochg_valid", 32'(out_valid), 32'd0);

    // Toggles while disabled are ignored and prev is kept
    step(1'b0, 5'b01001, 1'b1);
    step(1'b0, 5'b11111, 1'b1);
    step(1'b0, 5'b00000, 1'b1);
    step(1'b1, 5'b10110, 1'b1);
    chk("gate_cnt", 32'(change_cnt), 32'd1);
    chk("gate_valid", 32'(out_valid), 32'd0);

    // Overflow: six changes into a four-entry FIFO
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b1, ov_v[i], 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(change_cnt), 32'd6);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_valid", 32'(out_valid), 32'd1);
      chk("ovf_drain_data", 32'(out_data), 32'({ov_v[i], 8'(i)}));
      step(1'b0, 5'd0, 1'b1);
    end
    chk("ovf_empty", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous pop and push
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, ov_v[i], 1'b0);
    chk("full_level", 32'(fifo_level), 32'd4);
    step(1'b1, 5'b11000, 1'b1);
    chk("fullpop_level", 32'(fifo_level), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_head", 32'(out_data), 32'({5'd2, 8'd1}));
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b1);
    chk("fullpop_last", 32'(out_data), 32'({5'b11000, 8'd4}));
    step(1'b0, 5'd0, 1'b1);

    // Timestamp wrap 255 -> 0
    do_reset(1);
    for (int i = 0; i < 255; i++) step(1'b0, 5'd0, 1'b1);
    step(1'b1, 5'b00111, 1'b0);
    step(1'b1, 5'b01000, 1'b0);
    chk("wrap_level", 32'(fifo_level), 32'd2);
    chk("wrap_ff", 32'(out_data), 32'({5'b00111, 8'hFF}));
    step(1'b0, 5'd0, 1'b1);
    chk("wrap_00", 32'(out_data), 32'({5'b01000, 8'h00}));
    step(1'b0, 5'd0, 1'b1);

    // Counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, 1'b1);
    chk("sat_cnt", 32'(change_cnt), 32'd255);
    step(1'b0, 5'd0, 1'b1);

    // Reset with three queued records flushes everything
    step(1'b1, 5'h11, 1'b0);
    step(1'b1, 5'h12, 1'b0);
    step(1'b1, 5'h13, 1'b0);
    chk("preflush_level", 32'(fifo_level), 32'd3);
    do_reset(1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_level", 32'(fifo_level), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_cnt", 32'(change_cnt), 32'd0);
    step(1'b0, 5'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
